nios_ii_system_multi_timer: RTL and testbench
=============================================

# nios_ii_system_multi_timer

Parametrised multi-channel interval timer, Avalon-MM slave on the Nios II system bus. It provides NUM_CH independent down-counters of CNT_W bits, each with a per-channel prescaler, one-shot/continuous mode, snapshot capture and a maskable timeout interrupt. Per-channel IRQs are exported individually and as a wired-OR summary. Optionally, adjacent channels cascade into wider timers.

## Interface
- NUM_CH, 4: number of channels, 1..8.
- CNT_W, 32: counter/period width, 8..32.
- PRE_W, 8: prescaler width, 1..16.
- RESET_PERIOD, 49999: reset value of every period register and counter.
- clk  in  1  system clock, single domain.
- reset_n  in  1  synchronous, active-low reset.
- address  in  clog2(NUM_CH)+3  {channel, reg[2:0]}.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, single-cycle.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq_vec  out  NUM_CH  per-channel interrupt.
- irq  out  1  OR of irq_vec.

## Operation
- Write strobe is chipselect & ~write_n. Reads are always enabled; readdata captures the addressed register every cycle. Unused bits read 0.
- Per-channel registers:
  - reg 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - reg 1 CONTROL: bit0 ITO (IRQ enable), bit1 CONT, bit2 START, bit3 STOP, bit4 CASC. Bits 2 and 3 are strobes and read back as written.
  - reg 2 PERIOD: CNT_W bits.
  - reg 3 SNAP: a write copies the counter into SNAP; a read returns SNAP.
  - reg 4 PRESCALE: PRE_W bits.
  - reg 5–7 read 0; writes to them are ignored.
  - Channel index ≥ NUM_CH reads 0; writes to it are ignored.
- Tick generation: the prescaler counts down while RUN=1. A tick occurs when the prescaler is 0, and the prescaler then reloads from PRESCALE. PRESCALE=0 gives a tick every cycle.
- On a tick:
  - counter≠0: decrement.
  - counter=0: reload from PERIOD, set TO, and clear RUN if CONT=0.
- Timeout interval is (PERIOD+1)·(PRESCALE+1) cycles.
- Writing PERIOD or PRESCALE:
  - next cycle, the counter reloads from PERIOD and the prescaler from PRESCALE;
  - RUN clears (force reload, as in the single timer).
- START sets RUN. STOP clears RUN. The counter holds its value while stopped.
- irq_vec[n] = TO[n] & ITO[n].

## Timing
- Read latency: 1 cycle (readdata valid the cycle after the address is presented).
- Register writes take effect at the next clock edge.
- START → first decrement: 1 cycle after RUN sets, with PRESCALE=0.
- TO and irq assert in the cycle after the zero-tick edge.
- Simultaneous events:
  - START and STOP in the same write: START wins.
  - Status clear and timeout set in the same cycle: set wins (no lost event).
  - PERIOD write while running: the counter stops and reloads; START is needed to resume.
  - Snapshot in the same cycle as a decrement: captures the pre-decrement value.
- Reset (synchronous, any time, mid-count included):
  - counters and PERIOD = RESET_PERIOD;
  - prescalers, PRESCALE, CONTROL, TO, RUN, SNAP, readdata, irq_vec, irq = 0.

## Configuration
- MULTI_TIMER_CASCADE_EN defined:
  - For n≥1, CASC[n]=1 makes channel n tick only on channel n-1's zero-tick, instead of on its own prescaler.
  - Chained channels form an n·CNT_W-bit timer.
  - CASC[0] is ignored and reads 0.
- Not defined:
  - CASC bits are not implemented and read 0.
  - All channels tick from their own prescalers.
  - No inter-channel logic is synthesised.

## Test plan
- Reset, then read all registers → PERIOD=49999 (0xC34F), all other registers 0, irq=0.
- ch1: PERIOD=9, PRESCALE=0, CONTROL=0x7 → TO every 10 cycles, irq_vec=0b0010, RUN stays 1. Status write → irq drops next cycle.
- ch0: PERIOD=3, PRESCALE=4, CONTROL=0x5 (one-shot) → single TO 20 cycles after start, then RUN=0 and the counter reads 3.
- ch2 running, PERIOD written to 100 mid-count → RUN=0 and counter=100 next cycle; snapshot then reads 100.
- Simultaneous status-clear and timeout on ch3 → TO remains 1. Reset asserted mid-count → all values return to reset values within 1 cycle.
- With MULTI_TIMER_CASCADE_EN: ch0 PERIOD=1, ch1 PERIOD=2 with CASC=1, both started with CONT=1 → ch1 TO after 6 cycles. Without the macro, CONTROL bit4 reads 0.

Source files
------------

// File: rtl/nios_ii_system_multi_timer.sv
// Multi-channel Avalon-MM interval timer with prescalers, snapshot and per-channel IRQs.
// Define MULTI_TIMER_CASCADE_EN to let channel n tick from channel n-1's zero-tick (CASC bit).
module nios_ii_system_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [$clog2(NUM_CH)+2:0]  address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic [NUM_CH-1:0]          irq_vec,
  output logic                       irq
);

  localparam int AW = $clog2(NUM_CH) + 3;

  logic          wr_en;
  logic [2:0]    reg_sel;
  logic [AW-1:0] ch_sel;
  logic [31:0]   rd_val [NUM_CH];
  logic [31:0]   rd_next;

  assign wr_en   = chipselect && !write_n;
  assign reg_sel = address[2:0];
  assign ch_sel  = address >> 3;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [CNT_W-1:0] cnt, period, snap;
    logic [PRE_W-1:0] pre_cnt, prescale;
    logic             to, run, ito, cont, start_b, stop_b, casc;
    logic             sel, wr_status, wr_ctrl, wr_period, wr_snap, wr_pre;
    logic             own_tick, tick, zero_tick;

    assign sel       = wr_en && (ch_sel == AW'(n));
    assign wr_status = sel && (reg_sel == 3'd0);
    assign wr_ctrl   = sel && (reg_sel == 3'd1);
    assign wr_period = sel && (reg_sel == 3'd2);
    assign wr_snap   = sel && (reg_sel == 3'd3);
    assign wr_pre    = sel && (reg_sel == 3'd4);

    assign own_tick  = run && (pre_cnt == '0);

`ifdef MULTI_TIMER_CASCADE_EN
    if (n == 0) begin : g_src
      assign tick = own_tick;
    end else begin : g_src
      // A cascaded channel advances only when its lower neighbour wraps.
      assign tick = casc ? (run && g_ch[n-1].zero_tick) : own_tick;
    end

    always_ff @(posedge clk) begin
      if (!reset_n)
        casc <= 1'b0;
      else if (wr_ctrl)
        casc <= (n > 0) && writedata[4];
    end
`else
    assign tick = own_tick;
    assign casc = 1'b0;
`endif

    assign zero_tick  = tick && (cnt == '0);
    assign irq_vec[n] = to && ito;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt      <= CNT_W'(RESET_PERIOD);
        period   <= CNT_W'(RESET_PERIOD);
        snap     <= '0;
        pre_cnt  <= '0;
        prescale <= '0;
        to       <= 1'b0;
        run      <= 1'b0;
        ito      <= 1'b0;
        cont     <= 1'b0;
        start_b  <= 1'b0;
        stop_b   <= 1'b0;
      end else begin
        if (wr_period) period   <= writedata[CNT_W-1:0];
        if (wr_pre)    prescale <= writedata[PRE_W-1:0];
        if (wr_snap)   snap     <= cnt;
        if (wr_ctrl) begin
          ito     <= writedata[0];
          cont    <= writedata[1];
          start_b <= writedata[2];
          stop_b  <= writedata[3];
        end

        // A timeout in the same cycle as a status write must not be lost.
        if (zero_tick)      to <= 1'b1;
        else if (wr_status) to <= 1'b0;

        if (wr_period || wr_pre)          run <= 1'b0;
        else if (wr_ctrl && writedata[2]) run <= 1'b1;
        else if (wr_ctrl && writedata[3]) run <= 1'b0;
        else if (zero_tick && !cont)      run <= 1'b0;

        if (wr_period)   cnt <= writedata[CNT_W-1:0];
        else if (wr_pre) cnt <= period;
        else if (tick)   cnt <= (cnt == '0) ? period : cnt - 1'b1;

        if (wr_pre)         pre_cnt <= writedata[PRE_W-1:0];
        else if (wr_period) pre_cnt <= prescale;
        else if (run)       pre_cnt <= (pre_cnt == '0) ? prescale : pre_cnt - 1'b1;
      end
    end

    always_comb begin
      rd_val[n] = '0;
      case (reg_sel)
        3'd0:    rd_val[n] = {30'd0, run, to};
        3'd1:    rd_val[n] = {27'd0, casc, stop_b, start_b, cont, ito};
        3'd2:    rd_val[n] = 32'(period);
        3'd3:    rd_val[n] = 32'(snap);
        3'd4:    rd_val[n] = 32'(prescale);
        default: rd_val[n] = '0;
      endcase
    end
  end

  always_comb begin
    rd_next = '0;
    for (int n = 0; n < NUM_CH; n++)
      if (ch_sel == AW'(n)) rd_next = rd_val[n];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_nios_ii_system_multi_timer.sv
// Scoreboard bench for nios_ii_system_multi_timer: directed register and interrupt scenarios.
module tb_nios_ii_system_multi_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  irq_vec;
  logic        irq;

  always #5 clk = ~clk;

  nios_ii_system_multi_timer #(
    .NUM_CH(4), .CNT_W(32), .PRE_W(8), .RESET_PERIOD(49999)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_vec(irq_vec), .irq(irq)
  );

  typedef struct {
    bit          is_irq;
    logic [31:0] exp;
    logic [3:0]  vec;
    string       name;
  } exp_t;

  exp_t sb[$];
  logic req = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  // Monitor: a request seen at a rising edge is checked just after that edge.
  initial begin
    exp_t t;
    forever begin
      @(posedge clk);
      if (req) begin
        #1;
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL monitor: output presented with empty scoreboard");
        end else begin
          t = sb.pop_front();
          if (t.is_irq) begin
            cmp({t.name, ".irq_vec"}, 32'(irq_vec), 32'(t.vec));
            cmp({t.name, ".irq"}, 32'(irq), 32'(|t.vec));
          end else begin
            cmp(t.name, readdata, t.exp);
          end
        end
      end
    end
  end

  // All tasks start and end at a falling edge.
  task automatic wr(input int ch, input int r, input logic [31:0] d);
    address = 5'(ch * 8 + r);
    chipselect = 1'b1;
    write_n = 1'b0;
    writedata = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input int ch, input int r, input logic [31:0] e, input string nm);
    exp_t t;
    t.is_irq = 1'b0; t.exp = e; t.vec = '0; t.name = nm;
    sb.push_back(t);
    address = 5'(ch * 8 + r);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  // Checks interrupt outputs as they stand after the next rising edge.
  task automatic chk(input logic [3:0] v, input string nm);
    exp_t t;
    t.is_irq = 1'b1; t.exp = '0; t.vec = v; t.name = nm;
    sb.push_back(t);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk(4'b0000, "irq_in_reset");
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 8; r++)
        rd(c, r, (r == 2) ? 32'd49999 : 32'd0, $sformatf("rst_ch%0d_reg%0d", c, r));

    // ch1: continuous, period 9, prescale 0, IRQ enabled
    wr(1, 2, 9);
    wr(1, 4, 0);
    wr(1, 1, 32'h7);
    repeat (8) @(negedge clk);
    chk(4'b0000, "ch1_before_to");
    chk(4'b0010, "ch1_first_to");
    rd(1, 0, 32'h3, "ch1_status_to_run");
    wr(1, 0, 0);
    chk(4'b0000, "ch1_irq_cleared");
    repeat (6) @(negedge clk);
    chk(4'b0010, "ch1_second_to");
    rd(1, 0, 32'h3, "ch1_still_running");
    wr(1, 1, 32'h8);
    rd(1, 1, 32'h8, "ch1_ctrl_stop_readback");
    wr(1, 0, 0);

    // ch0: one-shot, period 3, prescale 4
    wr(0, 2, 3);
    wr(0, 4, 4);
    wr(0, 1, 32'h5);
    repeat (18) @(negedge clk);
    chk(4'b0000, "ch0_before_to");
    chk(4'b0001, "ch0_oneshot_to");
    rd(0, 0, 32'h1, "ch0_status_stopped");
    wr(0, 3, 0);
    rd(0, 3, 32'd3, "ch0_snap_reloaded");
    rd(0, 4, 32'd4, "ch0_prescale");
    wr(0, 0, 0);
    wr(0, 1, 0);

    // ch2: PERIOD written while running
    wr(2, 4, 0);
    wr(2, 1, 32'h6);
    repeat (3) @(negedge clk);
    wr(2, 2, 100);
    rd(2, 0, 32'h0, "ch2_run_cleared");
    rd(2, 1, 32'h6, "ch2_ctrl_readback");
    wr(2, 3, 0);
    rd(2, 3, 32'd100, "ch2_snap_100");
    rd(2, 2, 32'd100, "ch2_period_100");

    // ch3: status clear lands on the timeout edge
    wr(3, 2, 4);
    wr(3, 4, 0);
    wr(3, 1, 32'h7);
    repeat (4) @(negedge clk);
    wr(3, 0, 0);
    rd(3, 0, 32'h3, "ch3_to_set_wins");
    chk(4'b1000, "ch3_irq_held");

    // Reset mid-count
    reset_n = 1'b0;
    chk(4'b0000, "irq_mid_reset");
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 5; r++)
        rd(c, r, (r == 2) ? 32'd49999 : 32'd0, $sformatf("midrst_ch%0d_reg%0d", c, r));
    wr(3, 3, 0);
    rd(3, 3, 32'd49999, "ch3_counter_after_reset");

`ifdef MULTI_TIMER_CASCADE_EN
    wr(0, 2, 1);
    wr(1, 2, 2);
    wr(1, 1, 32'h17);
    wr(0, 1, 32'h6);
    repeat (4) @(negedge clk);
    chk(4'b0000, "casc_before_to");
    chk(4'b0010, "casc_ch1_to");
    rd(1, 1, 32'h17, "casc_ctrl_readback");
    wr(0, 1, 32'h10);
    rd(0, 1, 32'h0, "casc0_reads_zero");
`else
    wr(1, 1, 32'h10);
    rd(1, 1, 32'h0, "casc_bit_absent");
`endif

    repeat (2) @(negedge clk);
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
